// File: rtl/lfsr_range_gen.sv
// Fibonacci LFSR random source with seed load, free-run stepping and a
// req/valid bounded-draw port using masked rejection sampling with fallback.
module lfsr_range_gen #(
    parameter int               WIDTH     = 9,
    parameter logic [WIDTH-1:0] TAPS      = 9'h131,
    parameter logic [WIDTH-1:0] SEED      = 9'h001,
    parameter int               MAX_TRIES = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             step_en,
    input  logic             req,
    input  logic [WIDTH-1:0] limit,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] rand_out,
    output logic [WIDTH-1:0] raw_out
);

    localparam int               TRIES_W  = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] SEED_EFF = (SEED == ZERO) ? ONE : SEED;
    localparam logic [TRIES_W-1:0] LAST_TRY = TRIES_W'(MAX_TRIES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Smallest all-ones mask covering every value below lim; 0 for lim of 0 or 1.
    function automatic logic [WIDTH-1:0] range_mask(input logic [WIDTH-1:0] lim);
        logic [WIDTH-1:0] top;
        logic [WIDTH-1:0] m;
        top = lim - ONE;
        m   = ZERO;
        for (int i = 0; i < WIDTH; i++) begin
            if ((top >> i) != ZERO) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        if (lim <= ONE) begin
            m = ZERO;
        end
        return m;
    endfunction

    state_t             state_r, state_nxt_s;
    logic [WIDTH-1:0]   lfsr_r, lfsr_nxt_s;
    logic [WIDTH-1:0]   limit_q_r, limit_q_nxt_s;
    logic [WIDTH-1:0]   mask_q_r, mask_q_nxt_s;
    logic               full_q_r, full_q_nxt_s;
    logic [TRIES_W-1:0] tries_r, tries_nxt_s;
    logic [WIDTH-1:0]   rand_r, rand_nxt_s;
    logic               busy_r, valid_r;
    logic               fb_s, accept_s;
    logic [WIDTH-1:0]   step_s, cand_s;

    // LFSR step, candidate extraction and next LFSR value.
    always_comb begin
        fb_s     = ^(lfsr_r & TAPS);
        step_s   = {lfsr_r[WIDTH-2:0], fb_s};
        cand_s   = full_q_r ? lfsr_r : (lfsr_r & mask_q_r);
        accept_s = full_q_r || (cand_s < limit_q_r);
        if (seed_load) begin
            lfsr_nxt_s = (seed_in == ZERO) ? ONE : seed_in;
        end else if (step_en || (state_r == ST_DRAW)) begin
            lfsr_nxt_s = step_s;
        end else begin
            lfsr_nxt_s = lfsr_r;
        end
    end

    // Draw FSM next-state and datapath updates.
    always_comb begin
        state_nxt_s   = state_r;
        limit_q_nxt_s = limit_q_r;
        mask_q_nxt_s  = mask_q_r;
        full_q_nxt_s  = full_q_r;
        tries_nxt_s   = tries_r;
        rand_nxt_s    = rand_r;
        case (state_r)
            ST_IDLE: begin
                if (req) begin
                    limit_q_nxt_s = limit;
                    mask_q_nxt_s  = range_mask(limit);
                    full_q_nxt_s  = (limit == ZERO);
                    tries_nxt_s   = {TRIES_W{1'b0}};
                    state_nxt_s   = ST_DRAW;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_DRAW: begin
                if (accept_s) begin
                    rand_nxt_s  = cand_s;
                    state_nxt_s = ST_DONE;
                end else if (tries_r == LAST_TRY) begin
                    // cand < 2*limit here, so one subtraction lands in range
                    rand_nxt_s  = cand_s - limit_q_r;
                    state_nxt_s = ST_DONE;
                end else begin
                    tries_nxt_s = tries_r + TRIES_W'(1);
                    state_nxt_s = ST_DRAW;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r   <= ST_IDLE;
            lfsr_r    <= SEED_EFF;
            limit_q_r <= ZERO;
            mask_q_r  <= ZERO;
            full_q_r  <= 1'b0;
            tries_r   <= {TRIES_W{1'b0}};
            rand_r    <= ZERO;
            busy_r    <= 1'b0;
            valid_r   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            lfsr_r    <= lfsr_nxt_s;
            limit_q_r <= limit_q_nxt_s;
            mask_q_r  <= mask_q_nxt_s;
            full_q_r  <= full_q_nxt_s;
            tries_r   <= tries_nxt_s;
            rand_r    <= rand_nxt_s;
            busy_r    <= (state_nxt_s != ST_IDLE);
            valid_r   <= (state_nxt_s == ST_DONE);
        end
    end

    assign busy     = busy_r;
    assign valid    = valid_r;
    assign rand_out = rand_r;
    assign raw_out  = lfsr_r;

endmodule

// File: tb/tb_lfsr_range_gen.sv
// Directed bench for lfsr_range_gen: default instance plus a MAX_TRIES=1
// instance sharing the same stimulus.
module tb_lfsr_range_gen;

    localparam int W = 9;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         seed_load;
    logic [W-1:0] seed_in;
    logic         step_en;
    logic         req;
    logic [W-1:0] limit;
    logic         busy1, valid1, busy2, valid2;
    logic [W-1:0] rand1, raw1, rand2, raw2;

    int n_tests = 0;
    int n_fail  = 0;

    lfsr_range_gen #(.WIDTH(W), .TAPS(9'h131), .SEED(9'h001), .MAX_TRIES(8)) dut (
        .Clk(Clk), .Reset(Reset), .seed_load(seed_load), .seed_in(seed_in),
        .step_en(step_en), .req(req), .limit(limit), .busy(busy1),
        .valid(valid1), .rand_out(rand1), .raw_out(raw1)
    );

    lfsr_range_gen #(.WIDTH(W), .TAPS(9'h131), .SEED(9'h001), .MAX_TRIES(1)) dut_t1 (
        .Clk(Clk), .Reset(Reset), .seed_load(seed_load), .seed_in(seed_in),
        .step_en(step_en), .req(req), .limit(limit), .busy(busy2),
        .valid(valid2), .rand_out(rand2), .raw_out(raw2)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic load_seed(input logic [W-1:0] s);
        seed_load = 1'b1;
        seed_in   = s;
        tick();
        seed_load = 1'b0;
    endtask

    // Issue one request on the default instance and wait (bounded) for valid.
    task automatic draw(input logic [W-1:0] lim, output logic [W-1:0] val);
        int cyc;
        limit = lim;
        req   = 1'b1;
        tick();
        req = 1'b0;
        cyc = 0;
        while (valid1 !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        if (valid1 !== 1'b1) begin
            check_eq("draw_timeout", 32'(valid1), 32'd1);
        end
        val = rand1;
        tick();
    endtask

    initial begin
        logic [W-1:0] v;
        logic [4:0]   seen;
        logic         got_valid;

        Reset = 1'b1; seed_load = 1'b0; seed_in = 9'd0;
        step_en = 1'b0; req = 1'b0; limit = 9'd0;
        repeat (2) @(posedge Clk);
        #1;
        check_eq("rst_raw",   32'(raw1),   32'h001);
        check_eq("rst_busy",  32'(busy1),  32'd0);
        check_eq("rst_valid", 32'(valid1), 32'd0);
        check_eq("rst_rand",  32'(rand1),  32'h000);
        Reset = 1'b0;
        tick();
        check_eq("hold_raw", 32'(raw1), 32'h001);

        step_en = 1'b1;
        tick(); check_eq("step1", 32'(raw1), 32'h003);
        tick(); check_eq("step2", 32'(raw1), 32'h007);
        step_en = 1'b0;
        tick(); check_eq("step_hold", 32'(raw1), 32'h007);

        load_seed(9'h000); check_eq("seed_zero", 32'(raw1), 32'h001);
        load_seed(9'h0A5); check_eq("seed_a5",   32'(raw1), 32'h0A5);
        step_en = 1'b1;
        load_seed(9'h05A); check_eq("seed_prio", 32'(raw1), 32'h05A);
        step_en = 1'b0;

        // limit=1: only value 0, two-cycle latency
        load_seed(9'h003);
        limit = 9'd1; req = 1'b1;
        tick(); req = 1'b0;
        check_eq("l1_busy_c1",  32'(busy1),  32'd1);
        check_eq("l1_valid_c1", 32'(valid1), 32'd0);
        tick();
        check_eq("l1_busy_c2",  32'(busy1),  32'd1);
        check_eq("l1_valid_c2", 32'(valid1), 32'd1);
        check_eq("l1_rand",     32'(rand1),  32'h000);
        tick();
        check_eq("l1_busy_c3",  32'(busy1),  32'd0);
        check_eq("l1_valid_c3", 32'(valid1), 32'd0);
        check_eq("l1_raw_adv",  32'(raw1),   32'h007);

        // limit=3 from seed 3: default rejects 003,007,00F,01F then takes 03E&3=2;
        // MAX_TRIES=1 falls back to 3-3=0. limit changed mid-draw has no effect.
        load_seed(9'h003);
        limit = 9'd3; req = 1'b1;
        tick(); req = 1'b0; limit = 9'd0;
        for (int k = 1; k <= 7; k++) begin
            if (k > 1) tick();
            check_eq($sformatf("l3_v1_k%0d", k), 32'(valid1), 32'(k == 6));
            check_eq($sformatf("l3_v2_k%0d", k), 32'(valid2), 32'(k == 2));
            if (k == 2) check_eq("l3_fallback", 32'(rand2), 32'h000);
            if (k == 6) check_eq("l3_accept",   32'(rand1), 32'h002);
        end
        tick();

        // limit=0: full range returns raw state seen in DRAW
        load_seed(9'h0A5);
        limit = 9'd0; req = 1'b1;
        tick(); req = 1'b0;
        check_eq("full_raw_draw", 32'(raw1), 32'h0A5);
        tick();
        check_eq("full_valid", 32'(valid1), 32'd1);
        check_eq("full_rand",  32'(rand1),  32'h0A5);
        tick();

        // 1000 draws below 5
        load_seed(9'h001);
        seen = 5'd0;
        for (int i = 0; i < 1000; i++) begin
            draw(9'd5, v);
            check_eq("range5", 32'(v < 9'd5), 32'd1);
            if (v < 9'd5) seen[v[2:0]] = 1'b1;
        end
        check_eq("range5_all", 32'(seen), 32'h1F);

        // reset in the middle of a draw
        load_seed(9'h003);
        limit = 9'd3; req = 1'b1;
        tick(); req = 1'b0;
        tick();
        check_eq("mid_busy", 32'(busy1), 32'd1);
        #2 Reset = 1'b1;
        #1;
        check_eq("mr_busy",  32'(busy1),  32'd0);
        check_eq("mr_valid", 32'(valid1), 32'd0);
        check_eq("mr_raw",   32'(raw1),   32'h001);
        check_eq("mr_rand",  32'(rand1),  32'h000);
        check_eq("mr_busy2", 32'(busy2),  32'd0);
        @(posedge Clk);
        #1 Reset = 1'b0;
        got_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            got_valid = got_valid | valid1 | valid2;
        end
        check_eq("mr_no_valid", 32'(got_valid), 32'd0);
        check_eq("mr_raw_hold", 32'(raw1),      32'h001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
